fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the control unit. It reads 16-bit instruction words from instruction memory, assembles one-word (16-bit) or two-word (32-bit) instructions, and presents a registered instruction, its 7-bit opcode and its PC to the decode stage. It honours a stall from downstream and a PC redirect (branch/jump/interrupt) that flushes in-flight work.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/fetch_unit_if.sv | 31 +++
 rtl/fetch_unit.sv | 126 ++++++++++++
 tb/tb_fetch_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction word layout, fetch FSM states and
// the small helpers the fetch stage uses to take instructions apart.
package cpu_pkg;

  localparam int WORD_W   = 16;
  localparam int INSTR_W  = 32;
  localparam int OPC_W    = 7;
  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 9;
  localparam int LONG_BIT = 8;

  typedef enum logic [1:0] {
    FETCH_LO,
    FETCH_HI,
    HOLD
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic               is_long;
  } instr_t;

  // The opcode sits in the first word, which is always the upper half.
  function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[WORD_W+OPC_MSB : WORD_W+OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's instruction-memory port and decode-side port.
// master = fetch unit, slave = memory / decode environment.
interface fetch_unit_if #(
  parameter int PC_W = 32
);
  import cpu_pkg::*;

  logic [PC_W-1:0]    imem_addr;
  logic               imem_rd;
  logic [WORD_W-1:0]  imem_data;
  logic               imem_valid;
  logic               stall;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               id_valid;
  logic [INSTR_W-1:0] id_instr;
  logic [OPC_W-1:0]   id_opcode;
  logic               id_is_long;
  logic [PC_W-1:0]    id_pc;

  modport master (
    output imem_addr, imem_rd, id_valid, id_instr, id_opcode, id_is_long, id_pc,
    input  imem_data, imem_valid, stall, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_addr, imem_rd, id_valid, id_instr, id_opcode, id_is_long, id_pc,
    output imem_data, imem_valid, stall, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: assembles 16/32-bit instructions from 16-bit
// memory words and hands them to decode with stall and redirect support.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic         clk,
  input logic         reset,
  fetch_unit_if.master bus
);

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);
  localparam logic [PC_W-1:0] PC_TWO = PC_W'(2);

  fetch_state_t      state, state_nxt;
  logic [PC_W-1:0]   pc;
  logic [WORD_W-1:0] lo_buf;
  instr_t            pend_buf;
  logic [PC_W-1:0]   pend_pc;
  instr_t            id_buf;
  logic [PC_W-1:0]   id_pc;
  logic              id_valid;

  logic [WORD_W-1:0] word;
  logic              word_long;
  logic              can_load;
  logic              complete;
  instr_t            done_instr;

  assign word      = bus.imem_data;
  assign word_long = word[LONG_BIT];
  // Decode takes a new instruction when its register is empty or being consumed.
  assign can_load  = !id_valid || !bus.stall;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    complete   = 1'b0;
    done_instr = '0;
    case (state)
      FETCH_LO: if (bus.imem_valid && !word_long) begin
        complete   = 1'b1;
        done_instr = '{instr: {word, 16'h0000}, is_long: 1'b0};
      end
      FETCH_HI: if (bus.imem_valid) begin
        complete   = 1'b1;
        done_instr = '{instr: {lo_buf, word}, is_long: 1'b1};
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH_LO;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.redirect_valid) begin
      state_nxt = FETCH_LO;
    end else begin
      case (state)
        FETCH_LO: if (bus.imem_valid) begin
          if (word_long)     state_nxt = FETCH_HI;
          else if (can_load) state_nxt = FETCH_LO;
          else               state_nxt = HOLD;
        end
        FETCH_HI: if (bus.imem_valid) state_nxt = can_load ? FETCH_LO : HOLD;
        HOLD:     if (!bus.stall)     state_nxt = FETCH_LO;
        default:                      state_nxt = FETCH_LO;
      endcase
    end
  end

  // Reads stop in HOLD and are gated directly by reset so none leak out during it.
  always_comb begin
    bus.imem_rd   = reset && (state != HOLD);
    bus.imem_addr = (state == FETCH_HI) ? pc + PC_ONE : pc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_PC;
      lo_buf   <= '0;
      pend_buf <= '0;
      pend_pc  <= '0;
      id_buf   <= '0;
      id_pc    <= '0;
      id_valid <= 1'b0;
    end else if (bus.redirect_valid) begin
      pc       <= bus.redirect_pc;
      lo_buf   <= '0;
      pend_buf <= '0;
      pend_pc  <= '0;
      id_valid <= 1'b0;
    end else begin
      if (state == FETCH_LO && bus.imem_valid && word_long) lo_buf <= word;
      if (complete) pc <= pc + ((state == FETCH_HI) ? PC_TWO : PC_ONE);

      if (complete && can_load) begin
        id_buf   <= done_instr;
        id_pc    <= pc;
        id_valid <= 1'b1;
      end else if (complete) begin
        pend_buf <= done_instr;
        pend_pc  <= pc;
      end else if (state == HOLD && !bus.stall) begin
        id_buf   <= pend_buf;
        id_pc    <= pend_pc;
        id_valid <= 1'b1;
      end else if (!bus.stall) begin
        id_valid <= 1'b0;
      end
    end
  end

  assign bus.id_valid   = id_valid;
  assign bus.id_instr   = id_buf.instr;
  assign bus.id_opcode  = opcode_of(id_buf.instr);
  assign bus.id_is_long = id_buf.is_long;
  assign bus.id_pc      = id_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus hand-written
// wait-state, PC wrap-around and asynchronous reset sequences.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_unit_if #(.PC_W(32)) bus ();
  fetch_unit_if #(.PC_W(4))  bus4 ();

  fetch_unit #(.PC_W(32), .RESET_PC(32'h0)) dut  (.clk(clk), .reset(reset), .bus(bus));
  fetch_unit #(.PC_W(4),  .RESET_PC(4'h0))  dut4 (.clk(clk), .reset(reset), .bus(bus4));

  // Instruction memory models; the 32-bit one supports wait states.
  logic [15:0] mem  [256];
  logic [15:0] mem4 [16];
  int n_wait = 0;
  int wcnt   = 0;

  always_comb begin
    bus.imem_valid = bus.imem_rd && (wcnt >= n_wait);
    bus.imem_data  = mem[bus.imem_addr[7:0]];
    bus4.imem_valid = bus4.imem_rd;
    bus4.imem_data  = mem4[bus4.imem_addr];
  end

  always @(posedge clk) begin
    if (bus.imem_rd && !bus.imem_valid && !bus.redirect_valid) wcnt <= wcnt + 1;
    else                                                       wcnt <= 0;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        rd;
    logic [31:0] addr;
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        lng;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rp,
                              input logic rd, input logic [31:0] a, input logic vl,
                              input logic [31:0] in, input logic [31:0] p, input logic l);
    vec_t t;
    t.stall = s; t.rv = r; t.rpc = rp; t.rd = rd; t.addr = a;
    t.v = vl; t.instr = in; t.pc = p; t.lng = l;
    return t;
  endfunction

  vec_t tv[$];

  initial begin
    logic [31:0] exp_i;

    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 16; i++)  mem4[i] = 16'h0000;
    mem[8'h00] = 16'h2200; mem[8'h01] = 16'h0600; mem[8'h02] = 16'h3300;
    mem[8'h03] = 16'hBEEF; mem[8'h04] = 16'h0A00; mem[8'h05] = 16'h0C00;
    mem[8'h06] = 16'h0E00; mem[8'h07] = 16'h1000; mem[8'h08] = 16'h2500;
    mem[8'h09] = 16'h1234; mem[8'h40] = 16'h1400; mem[8'h41] = 16'h1600;
    mem[8'h42] = 16'h1800; mem[8'h10] = 16'h1A00; mem[8'h11] = 16'h1C00;
    mem[8'h20] = 16'h1E00; mem[8'h21] = 16'h2000; mem[8'h50] = 16'h2400;
    mem4[4'hF] = 16'h3300; mem4[4'h0] = 16'hBEEF; mem4[4'h1] = 16'h2200;

    // stall, redirect, redirect_pc | imem_rd, imem_addr, id_valid, id_instr, id_pc, id_is_long
    tv.push_back(mk(0, 0, 0,     1, 32'h00, 0, 32'h0,        32'h00, 0)); // c1
    tv.push_back(mk(0, 0, 0,     1, 32'h01, 1, 32'h22000000, 32'h00, 0)); // c2
    tv.push_back(mk(0, 0, 0,     1, 32'h02, 1, 32'h06000000, 32'h01, 0)); // c3 long lo
    tv.push_back(mk(0, 0, 0,     1, 32'h03, 0, 32'h0,        32'h00, 0)); // c4 long hi
    tv.push_back(mk(0, 0, 0,     1, 32'h04, 1, 32'h3300BEEF, 32'h02, 1)); // c5
    tv.push_back(mk(1, 0, 0,     1, 32'h05, 1, 32'h0A000000, 32'h04, 0)); // c6 stall
    tv.push_back(mk(1, 0, 0,     0, 32'h00, 1, 32'h0A000000, 32'h04, 0)); // c7 hold
    tv.push_back(mk(1, 0, 0,     0, 32'h00, 1, 32'h0A000000, 32'h04, 0)); // c8
    tv.push_back(mk(1, 0, 0,     0, 32'h00, 1, 32'h0A000000, 32'h04, 0)); // c9
    tv.push_back(mk(0, 0, 0,     0, 32'h00, 1, 32'h0A000000, 32'h04, 0)); // c10 release
    tv.push_back(mk(0, 0, 0,     1, 32'h06, 1, 32'h0C000000, 32'h05, 0)); // c11
    tv.push_back(mk(0, 0, 0,     1, 32'h07, 1, 32'h0E000000, 32'h06, 0)); // c12
    tv.push_back(mk(0, 0, 0,     1, 32'h08, 1, 32'h10000000, 32'h07, 0)); // c13 long lo
    tv.push_back(mk(0, 1, 32'h40, 1, 32'h09, 0, 32'h0,       32'h00, 0)); // c14 redirect in hi
    tv.push_back(mk(0, 0, 0,     1, 32'h40, 0, 32'h0,        32'h00, 0)); // c15
    tv.push_back(mk(0, 0, 0,     1, 32'h41, 1, 32'h14000000, 32'h40, 0)); // c16
    tv.push_back(mk(1, 0, 0,     1, 32'h42, 1, 32'h16000000, 32'h41, 0)); // c17 -> hold
    tv.push_back(mk(0, 1, 32'h10, 0, 32'h00, 1, 32'h16000000, 32'h41, 0)); // c18 redirect in hold
    tv.push_back(mk(0, 0, 0,     1, 32'h10, 0, 32'h0,        32'h00, 0)); // c19
    tv.push_back(mk(0, 0, 0,     1, 32'h11, 1, 32'h1A000000, 32'h10, 0)); // c20
    tv.push_back(mk(0, 1, 32'h20, 1, 32'h12, 1, 32'h1C000000, 32'h11, 0)); // c21
    tv.push_back(mk(1, 0, 0,     1, 32'h20, 0, 32'h0,        32'h00, 0)); // c22 stall, empty
    tv.push_back(mk(1, 0, 0,     1, 32'h21, 1, 32'h1E000000, 32'h20, 0)); // c23 -> hold
    tv.push_back(mk(0, 0, 0,     0, 32'h00, 1, 32'h1E000000, 32'h20, 0)); // c24
    tv.push_back(mk(0, 0, 0,     1, 32'h22, 1, 32'h20000000, 32'h21, 0)); // c25

    reset = 1'b0;
    bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    bus4.stall = 1'b0; bus4.redirect_valid = 1'b0; bus4.redirect_pc = '0;
    repeat (2) @(negedge clk);

    check("reset imem_rd",    {31'h0, bus.imem_rd},    32'h0);
    check("reset imem_addr",  bus.imem_addr,           32'h0);
    check("reset id_valid",   {31'h0, bus.id_valid},   32'h0);
    check("reset id_instr",   bus.id_instr,            32'h0);
    check("reset id_opcode",  {25'h0, bus.id_opcode},  32'h0);
    check("reset id_is_long", {31'h0, bus.id_is_long}, 32'h0);
    check("reset id_pc",      bus.id_pc,               32'h0);
    reset = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      if (i > 0) @(negedge clk);
      bus.stall          = tv[i].stall;
      bus.redirect_valid = tv[i].rv;
      bus.redirect_pc    = tv[i].rpc;
      #1;
      check($sformatf("c%0d imem_rd", i + 1), {31'h0, bus.imem_rd}, {31'h0, tv[i].rd});
      if (tv[i].rd)
        check($sformatf("c%0d imem_addr", i + 1), bus.imem_addr, tv[i].addr);
      check($sformatf("c%0d id_valid", i + 1), {31'h0, bus.id_valid}, {31'h0, tv[i].v});
      if (tv[i].v) begin
        exp_i = tv[i].instr;
        check($sformatf("c%0d id_instr", i + 1), bus.id_instr, exp_i);
        check($sformatf("c%0d id_opcode", i + 1), {25'h0, bus.id_opcode}, {25'h0, exp_i[31:25]});
        check($sformatf("c%0d id_pc", i + 1), bus.id_pc, tv[i].pc);
        check($sformatf("c%0d id_is_long", i + 1), {31'h0, bus.id_is_long}, {31'h0, tv[i].lng});
      end
    end

    // Hand-computed opcodes from the first instructions of the table.
    check("opcode 0x3300 long", {25'h0, 7'(32'h3300BEEF >> 25)}, 32'h19);

    // Two wait states: address held for three cycles, one instruction delivered.
    @(negedge clk);
    n_wait = 2;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h50;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("wait%0d imem_addr", k), bus.imem_addr, 32'h50);
      check($sformatf("wait%0d imem_rd", k), {31'h0, bus.imem_rd}, 32'h1);
      check($sformatf("wait%0d id_valid", k), {31'h0, bus.id_valid}, 32'h0);
      @(negedge clk);
    end
    #1;
    check("wait done id_valid", {31'h0, bus.id_valid}, 32'h1);
    check("wait done id_instr", bus.id_instr, 32'h24000000);
    check("wait done id_pc",    bus.id_pc,    32'h50);
    check("wait next addr",     bus.imem_addr, 32'h51);
    @(negedge clk);
    #1;
    check("wait single delivery", {31'h0, bus.id_valid}, 32'h0);
    n_wait = 0;

    // PC_W=4: long instruction at 0xF wraps its second word to address 0.
    @(negedge clk);
    bus4.redirect_valid = 1'b1; bus4.redirect_pc = 4'hF;
    @(negedge clk);
    bus4.redirect_valid = 1'b0;
    #1;
    check("wrap lo addr", {28'h0, bus4.imem_addr}, 32'hF);
    @(negedge clk);
    #1;
    check("wrap hi addr", {28'h0, bus4.imem_addr}, 32'h0);
    check("wrap hi rd",   {31'h0, bus4.imem_rd},   32'h1);
    @(negedge clk);
    #1;
    check("wrap id_valid",   {31'h0, bus4.id_valid},   32'h1);
    check("wrap id_instr",   bus4.id_instr,            32'h3300BEEF);
    check("wrap id_pc",      {28'h0, bus4.id_pc},      32'hF);
    check("wrap id_is_long", {31'h0, bus4.id_is_long}, 32'h1);
    check("wrap id_opcode",  {25'h0, bus4.id_opcode},  32'h19);
    check("wrap next addr",  {28'h0, bus4.imem_addr},  32'h1);

    // Asynchronous reset between clock edges while fetching.
    @(negedge clk);
    #1;
    check("pre-reset id_valid", {31'h0, bus.id_valid}, 32'h1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async reset id_valid",  {31'h0, bus.id_valid}, 32'h0);
    check("async reset imem_rd",   {31'h0, bus.imem_rd},  32'h0);
    check("async reset imem_addr", bus.imem_addr,         32'h0);
    check("async reset id_instr",  bus.id_instr,          32'h0);
    check("async reset id_pc",     bus.id_pc,             32'h0);
    check("async reset dut4 rd",   {31'h0, bus4.imem_rd}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
